// File: rtl/adbg_arb_pkg.sv
// adbg_arb_pkg: shared state encodings and debug port widths for the CPU port arbiter
package adbg_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    HOLD   = 2'd3
  } arb_state_e;
  localparam int ADBG_CPU_ADDR_W = 16;
  localparam int ADBG_CPU_DATA_W = 32;
endpackage

// File: rtl/adbg_rr_picker.sv
// adbg_rr_picker: first active request at or above ptr, wrapping, as one-hot and index
module adbg_rr_picker #(
  parameter int NB_REQ = 2,
  parameter int PW     = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [PW-1:0]     ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [PW-1:0]     idx_o
);
  logic [2*NB_REQ-1:0] rot;
  logic [PW-1:0]       off;
  logic [PW:0]         sum;
  assign rot = {req_i, req_i} >> ptr_i;
  // lowest set bit of the rotated vector is the offset from ptr; fold back modulo NB_REQ
  always_comb begin
    off = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) off = rot[i] ? PW'(i) : off;
    sum = {1'b0, ptr_i} + {1'b0, off};
    idx_o = (sum >= (PW+1)'(NB_REQ)) ? PW'(sum - (PW+1)'(NB_REQ)) : PW'(sum);
    for (int i = 0; i < NB_REQ; i++) gnt_o[i] = (|req_i) && (idx_o == PW'(i));
  end
endmodule

// File: rtl/adbg_cpu_port_arbiter.sv
// adbg_cpu_port_arbiter: round-robin sharing of one CPU debug port with access timeout
module adbg_cpu_port_arbiter
  import adbg_arb_pkg::*;
#(
  parameter int NB_REQ  = 2,
  parameter int ADDR_W  = ADBG_CPU_ADDR_W,
  parameter int DATA_W  = ADBG_CPU_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     cpu_clk_i,
  input  logic                     cpu_rst_i,
  input  logic [NB_REQ-1:0]        req_stb_i,
  input  logic [NB_REQ-1:0]        req_we_i,
  input  logic [NB_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NB_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NB_REQ-1:0]        req_ack_o,
  output logic [NB_REQ-1:0]        req_err_o,
  output logic [DATA_W-1:0]        req_rdata_o,
  output logic [NB_REQ-1:0]        grant_o,
  output logic                     busy_o,
  output logic                     cpu_stb_o,
  output logic                     cpu_we_o,
  output logic [ADDR_W-1:0]        cpu_addr_o,
  output logic [DATA_W-1:0]        cpu_data_o,
  input  logic [DATA_W-1:0]        cpu_data_i,
  input  logic                     cpu_ack_i
);
  localparam int PW = $clog2(NB_REQ);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  arb_state_e          state_q, state_d;
  logic [NB_REQ-1:0]   grant_q, grant_d, ack_q, ack_d, err_q, err_d, pick_gnt;
  logic [PW-1:0]       gidx_q, gidx_d, rr_q, rr_d, pick_idx;
  logic                stb_q, stb_d, we_q, we_d, busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  adbg_rr_picker #(.NB_REQ(NB_REQ), .PW(PW)) u_pick (
    .req_i (req_stb_i),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );
  // next-state and next-output decode; ack beats timeout in the same cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    stb_d   = stb_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: if (|req_stb_i) begin
        state_d = ACCESS;
        grant_d = pick_gnt;
        gidx_d  = pick_idx;
        we_d    = req_we_i[pick_idx];
        addr_d  = req_addr_i[pick_idx*ADDR_W +: ADDR_W];
        wdata_d = req_wdata_i[pick_idx*DATA_W +: DATA_W];
        stb_d   = 1'b1;
        cnt_d   = '0;
      end
      ACCESS: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (cpu_ack_i || (TIMEOUT != 0 && cnt_q == TO_LAST)) begin
          state_d = RESP;
          stb_d   = 1'b0;
          ack_d   = grant_q;
          err_d   = cpu_ack_i ? '0 : grant_q;
          rdata_d = cpu_ack_i ? cpu_data_i : '0;
        end
      end
      RESP: begin
        state_d = HOLD;
        rr_d    = (gidx_q == PW'(NB_REQ - 1)) ? '0 : gidx_q + 1'b1;
      end
      HOLD: if (!req_stb_i[gidx_q]) begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  // every output and the arbitration state are registered here
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      stb_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
    end
  end
  assign req_ack_o   = ack_q;
  assign req_err_o   = err_q;
  assign req_rdata_o = rdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign cpu_stb_o   = stb_q;
  assign cpu_we_o    = we_q;
  assign cpu_addr_o  = addr_q;
  assign cpu_data_o  = wdata_q;
endmodule
